// File: rtl/vga_pkg.sv
// vga_pkg: default VGA 640x480 timing, port-width helper and colour-field expansion.
package vga_pkg;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D = 33;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // Right-aligned fw-bit field widened to 8 bits by repeating it from the MSB down.
  function automatic logic [7:0] expand8(input logic [7:0] f, input int fw);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3'(7 - i)] = f[3'(fw - 1 - (i % fw))];
    return r;
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v raster counters, active-region decode and active-high raw syncs.
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D
) (
  input  logic clk,
  input  logic rst,
  output logic [cw(H_ACTIVE + H_FP + H_SYNC + H_BP)-1:0] o_h_cnt,
  output logic [cw(V_ACTIVE + V_FP + V_SYNC + V_BP)-1:0] o_v_cnt,
  output logic o_active,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_sof
);
  localparam int HW = cw(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = cw(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE = VW'(V_ACTIVE + V_FP + V_SYNC);
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end
  assign o_h_cnt = r_h;
  assign o_v_cnt = r_v;
  assign o_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign o_hsync = (r_h >= H_SS) && (r_h < H_SE);
  assign o_vsync = (r_v >= V_SS) && (r_v < V_SE);
  assign o_sof = (r_h == '0) && (r_v == '0);
endmodule

// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: VGA scan-out of a pixel-replicated frame buffer; all pins share a 2-clock latency.
module vga_fb_ctrl import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  parameter int SYNC_POL = 0,
  parameter int SCALE_SH = 2,
  parameter int PIX_W = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [cw(H_ACTIVE >> SCALE_SH)-1:0] wr_x,
  input  logic [cw(V_ACTIVE >> SCALE_SH)-1:0] wr_y,
  input  logic [PIX_W-1:0] wr_data,
  output logic hsync,
  output logic vsync,
  output logic valid,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic frame_start
);
  localparam int FB_W = H_ACTIVE >> SCALE_SH;
  localparam int FB_H = V_ACTIVE >> SCALE_SH;
  localparam int DEPTH = FB_W * FB_H;
  localparam int AW = cw(DEPTH);
  localparam int FW = PIX_W / 3;
  localparam int HW = cw(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = cw(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic POL = (SYNC_POL != 0);
  if ((PIX_W % 3) != 0 || PIX_W > 24) begin : g_bad_pix_w
    $error("vga_fb_ctrl: PIX_W must be a multiple of 3 and at most 24");
  end
  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic w_active, w_hs, w_vs, w_sof, w_wr_ok;
  logic [AW-1:0] w_raddr, w_waddr;
  logic [23:0] w_rgb;
  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PIX_W-1:0] r_rd;
  logic r_act1, r_hs1, r_vs1, r_sof1, r_act2, r_hs2, r_vs2, r_sof2;
  logic [23:0] r_rgb;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst(rst), .o_h_cnt(w_h), .o_v_cnt(w_v),
    .o_active(w_active), .o_hsync(w_hs), .o_vsync(w_vs), .o_sof(w_sof)
  );
  assign w_raddr = w_active ? AW'(int'(w_v >> SCALE_SH) * FB_W + int'(w_h >> SCALE_SH)) : '0;
  assign w_waddr = AW'(int'(wr_y) * FB_W + int'(wr_x));
  assign w_wr_ok = wr_en && (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);
  // Read and write share one edge, so a colliding read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_waddr] <= wr_data;
    r_rd <= r_mem[w_raddr];
  end
  assign w_rgb = r_act1 ? {expand8(8'(r_rd[PIX_W-1 -: FW]), FW),
                           expand8(8'(r_rd[2*FW-1 -: FW]), FW),
                           expand8(8'(r_rd[FW-1:0]), FW)} : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_act1, r_hs1, r_vs1, r_sof1} <= '0;
      {r_act2, r_hs2, r_vs2, r_sof2} <= '0;
      r_rgb <= '0;
    end else begin
      {r_act1, r_hs1, r_vs1, r_sof1} <= {w_active, w_hs, w_vs, w_sof};
      {r_act2, r_hs2, r_vs2, r_sof2} <= {r_act1, r_hs1, r_vs1, r_sof1};
      r_rgb <= w_rgb;
    end
  end
  assign hsync = r_hs2 ~^ POL;
  assign vsync = r_vs2 ~^ POL;
  assign valid = r_act2;
  assign frame_start = r_sof2;
  assign {vga_r, vga_g, vga_b} = r_rgb;
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// tb_vga_fb_ctrl: two small-timing instances checked cycle by cycle against a raster/frame-buffer model.
module tb_vga_fb_ctrl;
  localparam logic [27:0] BLANK = 28'hC000000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] we;
  logic [1:0][2:0] wx;
  logic [1:0][1:0] wy;
  logic [1:0][11:0] wd;
  logic [1:0] hs, vs, vl, fs;
  logic [1:0][7:0] r, g, b;
  int ha[2] = '{8, 12};
  int ht[2] = '{14, 18};
  int va[2] = '{4, 6};
  int vt[2] = '{7, 9};
  int sh[2] = '{0, 1};
  int fbw[2] = '{8, 6};
  int fbh[2] = '{4, 3};
  logic [11:0] mdl_mem [2][48];
  int pos[2];
  logic [27:0] e1[2], e2[2];
  int n_asrt = 0, n_fail = 0;
  int n, n1, n2;

  always #5 clk = ~clk;

  vga_fb_ctrl #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .SYNC_POL(0), .SCALE_SH(0), .PIX_W(12)) u_a (
    .clk(clk), .rst(rst), .wr_en(we[0]), .wr_x(wx[0]), .wr_y(wy[0]), .wr_data(wd[0]),
    .hsync(hs[0]), .vsync(vs[0]), .valid(vl[0]), .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]),
    .frame_start(fs[0]));
  vga_fb_ctrl #(.H_ACTIVE(12), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .SYNC_POL(0), .SCALE_SH(1), .PIX_W(12)) u_b (
    .clk(clk), .rst(rst), .wr_en(we[1]), .wr_x(wx[1]), .wr_y(wy[1]), .wr_data(wd[1]),
    .hsync(hs[1]), .vsync(vs[1]), .valid(vl[1]), .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]),
    .frame_start(fs[1]));

  function automatic logic [27:0] pins(input int d);
    return {hs[d], vs[d], vl[d], fs[d], r[d], g[d], b[d]};
  endfunction

  // Expected pins for raster position p of instance d: sync regions, visible area, replicated pixel.
  function automatic logic [27:0] model_px(input int d, input int p);
    int h, v;
    logic act, hsn, vsn;
    logic [11:0] px;
    h = p % ht[d];
    v = p / ht[d];
    act = (h < ha[d]) && (v < va[d]);
    hsn = (h >= ha[d] + 2) && (h < ha[d] + 4);
    vsn = (v >= va[d] + 1) && (v < va[d] + 2);
    px = 12'h0;
    if (act) px = mdl_mem[d][(v >> sh[d]) * fbw[d] + (h >> sh[d])];
    return {~hsn, ~vsn, act, p == 0, 8'(px[11:8]) * 8'h11, 8'(px[7:4]) * 8'h11, 8'(px[3:0]) * 8'h11};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        e1[d] = BLANK;
        e2[d] = BLANK;
        pos[d] = 0;
      end else begin
        e2[d] = e1[d];
        e1[d] = model_px(d, pos[d]);
        pos[d] = (pos[d] + 1) % (ht[d] * vt[d]);
      end
      if (we[d] && int'(wx[d]) < fbw[d] && int'(wy[d]) < fbh[d])
        mdl_mem[d][int'(wy[d]) * fbw[d] + int'(wx[d])] = wd[d];
    end
    @(negedge clk);
    chk("pins_a", pins(0), e2[0]);
    chk("pins_b", pins(1), e2[1]);
  endtask

  // sel: 0 hsync_a, 1 vsync_a, 2 frame_start_a, 3 frame_start_b
  task automatic wait_sig(input int sel, input logic lvl, input int lim, output int cnt);
    logic s;
    cnt = 0;
    do begin
      step();
      cnt++;
      s = (sel == 0) ? hs[0] : (sel == 1) ? vs[0] : fs[sel - 2];
    end while (s !== lvl && cnt < lim);
    chk($sformatf("wait_sel%0d", sel), s, lvl);
  endtask

  initial begin
    we = '0; wx = '0; wy = '0; wd = '0;
    for (int i = 0; i < 32; i++) begin
      we[0] = 1'b1; wx[0] = 3'(i % 8); wy[0] = 2'(i / 8); wd[0] = 12'($urandom);
      we[1] = (i < 18); wx[1] = 3'(i % 6); wy[1] = 2'(i / 6); wd[1] = 12'($urandom);
      step();
    end
    we = 2'b11; wx = '0; wy = '0; wd[0] = 12'hF00; wd[1] = 12'h000;
    step();
    we[0] = 1'b0; wx[1] = 3'd1; wd[1] = 12'h0F0;
    step();
    wx[1] = 3'd0; wy[1] = 2'd1; wd[1] = 12'h123;
    step();
    we = '0;
    chk("reset_a", pins(0), BLANK);
    chk("reset_b", pins(1), BLANK);
    rst = 1'b0;
    step();
    chk("pre_first_valid", vl[0], 1'b0);
    step();
    chk("first_fs_a", fs[0], 1'b1);
    chk("first_valid_a", vl[0], 1'b1);
    chk("first_rgb_a", {r[0], g[0], b[0]}, 24'hFF0000);
    wait_sig(0, 1'b0, 100, n);
    wait_sig(0, 1'b1, 100, n1);
    wait_sig(0, 1'b0, 100, n2);
    chk("hsync_low", n1, 2);
    chk("hsync_period", n1 + n2, 14);
    wait_sig(1, 1'b0, 300, n);
    wait_sig(1, 1'b1, 300, n1);
    wait_sig(1, 1'b0, 300, n2);
    chk("vsync_low", n1, 14);
    chk("vsync_period", n1 + n2, 98);
    wait_sig(3, 1'b1, 400, n);
    for (int k = 0; k < 36; k++) begin
      if (k % 18 < 4)
        chk($sformatf("b_px_x%0d_y%0d", k % 18, k / 18), {r[1], g[1], b[1]},
            (k % 18 >= 2) ? 24'h00FF00 : 24'h000000);
      step();
    end
    we[1] = 1'b1; wx[1] = 3'd6; wy[1] = 2'd0; wd[1] = 12'hFFF;
    step();
    wx[1] = 3'd0; wy[1] = 2'd3;
    step();
    we[1] = 1'b0;
    wait_sig(3, 1'b1, 400, n);
    repeat (36) step();
    chk("b_oob_keep", {r[1], g[1], b[1]}, 24'h112233);
    wait_sig(2, 1'b1, 200, n);
    repeat (96) step();
    we[0] = 1'b1; wx[0] = 3'd0; wy[0] = 2'd0; wd[0] = 12'h00F;
    step();
    we[0] = 1'b0;
    step();
    chk("rbw_fs", fs[0], 1'b1);
    chk("rbw_old", {r[0], g[0], b[0]}, 24'hFF0000);
    repeat (98) step();
    chk("rbw_fs_next", fs[0], 1'b1);
    chk("rbw_new", {r[0], g[0], b[0]}, 24'h0000FF);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_a", pins(0), BLANK);
    chk("midrst_b", pins(1), BLANK);
    step();
    chk("midrst_wait", vl[0], 1'b0);
    step();
    chk("midrst_fs", fs[0], 1'b1);
    chk("midrst_px", {r[0], g[0], b[0]}, 24'h0000FF);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 2; d++) begin
        we[d] = 1'($urandom_range(0, 1));
        wx[d] = 3'($urandom);
        wy[d] = 2'($urandom);
        wd[d] = 12'($urandom);
      end
      step();
    end
    rst = 1'b0;
    we = '0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
